usb_fsi_channel_mux: RTL and testbench
======================================

// Module: usb_fsi_channel_mux
// PURPOSE
//  Channel router between the FTDI fast-serial engine and the two logical USB channels (0 and 1).
//  RX: demuxes received bytes by channel bit into two per-channel FIFOs and throttles the serial link.
//  TX: buffers bytes from two per-channel FIFOs and arbitrates them onto the engine's single
//  valid/busy TX handshake.
// PARAMETERS
//  FIFO_AW   4   address width of each of the 4 internal FIFOs; depth = 2**FIFO_AW entries
// PORTS
//  i_clk            in   1  clock
//  i_reset          in   1  synchronous, active-high reset
//  o_fsi_rx_ready   out  1  to engine: RX may proceed (engine halts serial clock when low)
//  i_fsi_rx_valid   in   1  one-cycle pulse: received byte valid
//  i_fsi_rx_channel in   1  channel of received byte
//  i_fsi_rx_data    in   8  received byte
//  i_fsi_tx_busy    in   1  engine serialising a byte; offer accepted only while low
//  o_fsi_tx_valid   out  1  TX byte offered
//  o_fsi_tx_channel out  1  channel of offered byte
//  o_fsi_tx_data    out  8  offered byte
//  i_rxN_read       in   1  (N=0,1) pop head of RX FIFO N
//  o_rxN_empty      out  1  RX FIFO N empty
//  o_rxN_data       out  8  head of RX FIFO N (first-word fall-through)
//  i_txN_write      in   1  (N=0,1) push i_txN_data into TX FIFO N
//  o_txN_full       out  1  TX FIFO N full
//  i_txN_data       in   8  byte to transmit on channel N
//  o_rx_overflow    out  2  sticky per-channel RX drop flag, bit N = channel N
// BEHAVIOUR
//  Reset: all FIFOs empty (o_rxN_empty=1, o_txN_full=0), o_fsi_rx_ready=0, o_fsi_tx_valid=0,
//   o_fsi_tx_channel=0, o_fsi_tx_data=0, o_rx_overflow=2'b00, round-robin pointer=1.
//   Reset mid-byte discards all FIFO contents and any pending offer.
//  FIFOs: circular, pointers FIFO_AW+1 bits wide (MSB distinguishes full from empty); wrap silent.
//   Read while empty is ignored. Write while full is ignored.
//   Simultaneous read+write on a non-empty FIFO keeps its count unchanged.
//  RX path: on i_fsi_rx_valid, the byte is written to RX FIFO[i_fsi_rx_channel].
//   o_rxN_empty falls the cycle after the valid pulse.
//   If the target FIFO is full, the byte is dropped and o_rx_overflow[ch] is set.
//   Only reset clears o_rx_overflow.
//  o_fsi_rx_ready: registered; =1 iff BOTH RX FIFOs have >=2 free entries.
//   The 2-entry margin absorbs the one byte that can complete during the register delay.
//  TX FSM, states IDLE and OFFER:
//   IDLE: if !i_fsi_tx_busy and any TX FIFO is non-empty, select a channel and go to OFFER.
//    The selected head byte and channel are latched into o_fsi_tx_data/channel; o_fsi_tx_valid=1.
//   OFFER: hold the outputs stable. On a cycle with o_fsi_tx_valid && !i_fsi_tx_busy the offer
//    is accepted: pop that FIFO, o_fsi_tx_valid=0 next cycle, return to IDLE, rr pointer=channel.
//   Engine busy rises the cycle after acceptance, so the IDLE->OFFER gap is >=2 cycles. Never
//    re-offer in the acceptance cycle. Worst-case latency from push into an empty idle system
//    to o_fsi_tx_valid is 2 cycles.
//  Arbitration (default): round-robin. If both are non-empty, pick channel != rr pointer;
//   otherwise pick the only non-empty one.
//  Simultaneous push to a TX FIFO and pop of the same FIFO is legal: count is unchanged.
// CONFIGURATION
//  USB_FSI_TX_STRICT_PRIORITY_EN defined: channel 0 always wins when non-empty; channel 1 is
//   sent only while TX FIFO 0 is empty; the rr pointer is unused.
//  Not defined: round-robin as above.
// TESTING
//  1 Reset, then idle 2 cycles -> o_fsi_rx_ready=1, both o_rxN_empty=1, o_fsi_tx_valid=0.
//  2 RX pulses ch0 0xA5, ch1 0x3C, ch0 0x5A -> o_rx0_data=0xA5, then 0x5A after one read;
//    o_rx1_data=0x3C; no overflow.
//  3 FIFO_AW=2: 3 ch1 bytes -> rx_ready=0; 4th accepted; 5th dropped, o_rx_overflow=2'b10;
//    one read frees an entry.
//  4 Push 0x11,0x22 to tx0 and 0x33,0x44 to tx1, engine busy 20 cycles per byte ->
//    order 0x11,0x33,0x22,0x44 (strict-priority build: 0x11,0x22,0x33,0x44).
//  5 Offer pending with busy held high 50 cycles -> valid/data/channel stable throughout,
//    no pop, accepted on the first busy-low cycle.
//  6 Reset asserted in OFFER with bytes queued -> next cycle valid=0, all FIFOs empty,
//    overflow cleared.

Source files
------------

// File: rtl/usb_fsi_channel_mux.sv
// ----------------------------------------------------------------------------
// usb_fsi_channel_mux
//
// Routes bytes between the FTDI fast-serial engine and the two logical USB
// channels (0 and 1).
//   RX: received bytes are steered by their channel bit into one of two
//       RX FIFOs. o_fsi_rx_ready throttles the serial link.
//   TX: two TX FIFOs are arbitrated onto the engine's single valid/busy
//       handshake through a two-state offer FSM with registered outputs.
//
// Parameters
//   FIFO_AW   address width of each internal FIFO (depth = 2**FIFO_AW), >= 1
//
// Build option
//   USB_FSI_TX_STRICT_PRIORITY_EN  defined: channel 0 always wins when it has
//                                  data. Undefined: round-robin arbitration.
//
// Ports
//   i_clk, i_reset                           clock, synchronous active-high reset
//   o_fsi_rx_ready                           RX may proceed (both RX FIFOs have >= 2 free)
//   i_fsi_rx_valid/_channel/_data            received byte strobe, channel, data
//   i_fsi_tx_busy                            engine busy; an offer is taken while low
//   o_fsi_tx_valid/_channel/_data            offered TX byte
//   i_rxN_read, o_rxN_empty, o_rxN_data      RX FIFO N pop / empty / head (FWFT)
//   i_txN_write, o_txN_full, i_txN_data      TX FIFO N push / full / data
//   o_rx_overflow                            sticky per-channel RX drop flags
// ----------------------------------------------------------------------------
module usb_fsi_channel_mux #(
    parameter int unsigned FIFO_AW = 4
) (
    input  logic       i_clk,
    input  logic       i_reset,
    output logic       o_fsi_rx_ready,
    input  logic       i_fsi_rx_valid,
    input  logic       i_fsi_rx_channel,
    input  logic [7:0] i_fsi_rx_data,
    input  logic       i_fsi_tx_busy,
    output logic       o_fsi_tx_valid,
    output logic       o_fsi_tx_channel,
    output logic [7:0] o_fsi_tx_data,
    input  logic       i_rx0_read,
    output logic       o_rx0_empty,
    output logic [7:0] o_rx0_data,
    input  logic       i_rx1_read,
    output logic       o_rx1_empty,
    output logic [7:0] o_rx1_data,
    input  logic       i_tx0_write,
    output logic       o_tx0_full,
    input  logic [7:0] i_tx0_data,
    input  logic       i_tx1_write,
    output logic       o_tx1_full,
    input  logic [7:0] i_tx1_data,
    output logic [1:0] o_rx_overflow
);

    localparam int unsigned DEPTH = 2 ** FIFO_AW;
    localparam logic [FIFO_AW:0] PTR_ONE      = (FIFO_AW + 1)'(1);
    // Ready only while at most DEPTH-2 entries are used.
    localparam logic [FIFO_AW:0] RX_READY_MAX = (FIFO_AW + 1)'(DEPTH - 2);

    typedef enum logic {
        ST_IDLE,
        ST_OFFER
    } tx_state_t;

    // FIFO index map: 0 = RX0, 1 = RX1, 2 = TX0, 3 = TX1
    logic [7:0]       mem_q  [4][DEPTH];
    logic [FIFO_AW:0] wptr_q [4];
    logic [FIFO_AW:0] rptr_q [4];

    logic [3:0] fifo_empty, fifo_full;
    logic [3:0] wr_req, rd_req, wr_en, rd_en;
    logic [7:0] fifo_head [4];
    logic [7:0] fifo_wdata [4];

    logic [FIFO_AW:0] rx0_used, rx1_used;
    logic             rx_ready_d, rx_ready_q;
    logic [1:0]       rx_ovf_q;

    tx_state_t  tx_state_q;
    logic       tx_valid_q;
    logic       tx_chan_q;
    logic [7:0] tx_data_q;
    logic       tx_accept;
    logic       tx_any;
    logic       tx_sel;
`ifndef USB_FSI_TX_STRICT_PRIORITY_EN
    logic       rr_q;
`endif

    // ------------------------------------------------------------------
    // FIFO status, derived from pointers only
    // ------------------------------------------------------------------
    always_comb begin
        fifo_empty = '0;
        fifo_full  = '0;
        for (int unsigned f = 0; f < 4; f++) begin
            fifo_head[f]  = mem_q[f][rptr_q[f][FIFO_AW-1:0]];
            fifo_empty[f] = (wptr_q[f] == rptr_q[f]);
            fifo_full[f]  = (wptr_q[f][FIFO_AW] != rptr_q[f][FIFO_AW]) &&
                            (wptr_q[f][FIFO_AW-1:0] == rptr_q[f][FIFO_AW-1:0]);
        end
    end

    // ------------------------------------------------------------------
    // FIFO requests
    // ------------------------------------------------------------------
    assign tx_accept = tx_valid_q && !i_fsi_tx_busy;

    always_comb begin
        wr_req        = '0;
        rd_req        = '0;
        wr_req[0]     = i_fsi_rx_valid && !i_fsi_rx_channel;
        wr_req[1]     = i_fsi_rx_valid &&  i_fsi_rx_channel;
        wr_req[2]     = i_tx0_write;
        wr_req[3]     = i_tx1_write;
        rd_req[0]     = i_rx0_read;
        rd_req[1]     = i_rx1_read;
        rd_req[2]     = tx_accept && !tx_chan_q;
        rd_req[3]     = tx_accept &&  tx_chan_q;
        fifo_wdata[0] = i_fsi_rx_data;
        fifo_wdata[1] = i_fsi_rx_data;
        fifo_wdata[2] = i_tx0_data;
        fifo_wdata[3] = i_tx1_data;
    end

    // A full FIFO still takes a write when it is popped in the same cycle,
    // so simultaneous push and pop always leaves the count unchanged.
    always_comb begin
        rd_en = rd_req & ~fifo_empty;
        wr_en = wr_req & (~fifo_full | rd_en);
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            for (int unsigned f = 0; f < 4; f++) begin
                wptr_q[f] <= '0;
                rptr_q[f] <= '0;
            end
        end else begin
            for (int unsigned f = 0; f < 4; f++) begin
                if (wr_en[f]) wptr_q[f] <= wptr_q[f] + PTR_ONE;
                if (rd_en[f]) rptr_q[f] <= rptr_q[f] + PTR_ONE;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        for (int unsigned f = 0; f < 4; f++) begin
            if (wr_en[f] && !i_reset) begin
                mem_q[f][wptr_q[f][FIFO_AW-1:0]] <= fifo_wdata[f];
            end
        end
    end

    // ------------------------------------------------------------------
    // RX flow control and overflow
    // ------------------------------------------------------------------
    always_comb begin
        rx0_used   = wptr_q[0] - rptr_q[0];
        rx1_used   = wptr_q[1] - rptr_q[1];
        rx_ready_d = (rx0_used <= RX_READY_MAX) && (rx1_used <= RX_READY_MAX);
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            rx_ready_q <= 1'b0;
            rx_ovf_q   <= '0;
        end else begin
            rx_ready_q <= rx_ready_d;
            // An RX byte that the FIFO did not take is a drop.
            rx_ovf_q   <= rx_ovf_q | (wr_req[1:0] & ~wr_en[1:0]);
        end
    end

    // ------------------------------------------------------------------
    // TX arbitration and offer FSM
    // ------------------------------------------------------------------
    always_comb begin
        tx_any = !fifo_empty[2] || !fifo_empty[3];
`ifdef USB_FSI_TX_STRICT_PRIORITY_EN
        tx_sel = fifo_empty[2];
`else
        if (!fifo_empty[2] && !fifo_empty[3]) begin
            tx_sel = ~rr_q;
        end else begin
            tx_sel = fifo_empty[2];
        end
`endif
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            tx_state_q <= ST_IDLE;
            tx_valid_q <= 1'b0;
            tx_chan_q  <= 1'b0;
            tx_data_q  <= '0;
`ifndef USB_FSI_TX_STRICT_PRIORITY_EN
            rr_q       <= 1'b1;
`endif
        end else begin
            case (tx_state_q)
                ST_IDLE: begin
                    if (!i_fsi_tx_busy && tx_any) begin
                        tx_state_q <= ST_OFFER;
                        tx_valid_q <= 1'b1;
                        tx_chan_q  <= tx_sel;
                        tx_data_q  <= tx_sel ? fifo_head[3] : fifo_head[2];
                    end
                end
                ST_OFFER: begin
                    // Outputs hold until accepted; no re-offer in the
                    // acceptance cycle.
                    if (!i_fsi_tx_busy) begin
                        tx_state_q <= ST_IDLE;
                        tx_valid_q <= 1'b0;
`ifndef USB_FSI_TX_STRICT_PRIORITY_EN
                        rr_q       <= tx_chan_q;
`endif
                    end
                end
                default: begin
                    tx_state_q <= ST_IDLE;
                    tx_valid_q <= 1'b0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign o_fsi_rx_ready   = rx_ready_q;
    assign o_fsi_tx_valid   = tx_valid_q;
    assign o_fsi_tx_channel = tx_chan_q;
    assign o_fsi_tx_data    = tx_data_q;
    assign o_rx0_empty      = fifo_empty[0];
    assign o_rx1_empty      = fifo_empty[1];
    assign o_rx0_data       = fifo_head[0];
    assign o_rx1_data       = fifo_head[1];
    assign o_tx0_full       = fifo_full[2];
    assign o_tx1_full       = fifo_full[3];
    assign o_rx_overflow    = rx_ovf_q;

endmodule

// File: tb/tb_usb_fsi_channel_mux.sv
// ----------------------------------------------------------------------------
// tb_usb_fsi_channel_mux
//
// Self-checking bench for usb_fsi_channel_mux (FIFO_AW = 2, depth 4).
// A queue-based reference model tracks FIFO contents, overflow, RX ready and
// the pending TX offer; a compare process checks every output against it on
// each falling edge. Directed scenarios add literal expectations, then a
// randomized phase exercises the model comparison.
// ----------------------------------------------------------------------------
module tb_usb_fsi_channel_mux;

    localparam int AW    = 2;
    localparam int DEPTH = 4;

    logic       i_clk = 1'b0;
    logic       i_reset = 1'b1;
    logic       o_fsi_rx_ready;
    logic       i_fsi_rx_valid = 1'b0;
    logic       i_fsi_rx_channel = 1'b0;
    logic [7:0] i_fsi_rx_data = '0;
    logic       i_fsi_tx_busy = 1'b1;
    logic       o_fsi_tx_valid;
    logic       o_fsi_tx_channel;
    logic [7:0] o_fsi_tx_data;
    logic       i_rx0_read = 1'b0;
    logic       o_rx0_empty;
    logic [7:0] o_rx0_data;
    logic       i_rx1_read = 1'b0;
    logic       o_rx1_empty;
    logic [7:0] o_rx1_data;
    logic       i_tx0_write = 1'b0;
    logic       o_tx0_full;
    logic [7:0] i_tx0_data = '0;
    logic       i_tx1_write = 1'b0;
    logic       o_tx1_full;
    logic [7:0] i_tx1_data = '0;
    logic [1:0] o_rx_overflow;

    always #5 i_clk = ~i_clk;

    usb_fsi_channel_mux #(.FIFO_AW(AW)) dut (
        .i_clk            (i_clk),
        .i_reset          (i_reset),
        .o_fsi_rx_ready   (o_fsi_rx_ready),
        .i_fsi_rx_valid   (i_fsi_rx_valid),
        .i_fsi_rx_channel (i_fsi_rx_channel),
        .i_fsi_rx_data    (i_fsi_rx_data),
        .i_fsi_tx_busy    (i_fsi_tx_busy),
        .o_fsi_tx_valid   (o_fsi_tx_valid),
        .o_fsi_tx_channel (o_fsi_tx_channel),
        .o_fsi_tx_data    (o_fsi_tx_data),
        .i_rx0_read       (i_rx0_read),
        .o_rx0_empty      (o_rx0_empty),
        .o_rx0_data       (o_rx0_data),
        .i_rx1_read       (i_rx1_read),
        .o_rx1_empty      (o_rx1_empty),
        .o_rx1_data       (o_rx1_data),
        .i_tx0_write      (i_tx0_write),
        .o_tx0_full       (o_tx0_full),
        .i_tx0_data       (i_tx0_data),
        .i_tx1_write      (i_tx1_write),
        .o_tx1_full       (o_tx1_full),
        .i_tx1_data       (i_tx1_data),
        .o_rx_overflow    (o_rx_overflow)
    );

    int checks = 0;
    int errors = 0;
    bit cmp_en = 1'b0;

    // Reference model state
    logic [7:0] rxq0[$], rxq1[$], txq0[$], txq1[$];
    logic [1:0] m_ovf   = '0;
    bit         m_ready = 1'b0;
    bit         m_valid = 1'b0;
    bit         m_chan  = 1'b0;
    logic [7:0] m_data  = '0;
    bit         m_rr    = 1'b1;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // One clock edge of the reference model, from inputs and pre-edge state.
    task automatic model_step();
        int  n0, n1, t0, t1;
        bit  rd0, rd1, nready, pop, popc, start, selc;
        bit  acc0, acc1;
        logic [7:0] seld;
        if (i_reset) begin
            rxq0.delete(); rxq1.delete(); txq0.delete(); txq1.delete();
            m_ovf = '0; m_ready = 0; m_valid = 0; m_chan = 0; m_data = '0; m_rr = 1;
            return;
        end
        n0 = rxq0.size(); n1 = rxq1.size(); t0 = txq0.size(); t1 = txq1.size();
        rd0    = i_rx0_read && n0 > 0;
        rd1    = i_rx1_read && n1 > 0;
        nready = (DEPTH - n0 >= 2) && (DEPTH - n1 >= 2);
        pop    = m_valid && !i_fsi_tx_busy;
        popc   = m_chan;
        start  = !m_valid && !i_fsi_tx_busy && (t0 > 0 || t1 > 0);
        selc   = 0;
        seld   = '0;
        if (start) begin
`ifdef USB_FSI_TX_STRICT_PRIORITY_EN
            selc = (t0 > 0) ? 1'b0 : 1'b1;
`else
            if (t0 > 0 && t1 > 0) selc = !m_rr;
            else                  selc = (t0 > 0) ? 1'b0 : 1'b1;
`endif
            seld = selc ? txq1[0] : txq0[0];
        end
        // RX
        if (rd0) void'(rxq0.pop_front());
        if (rd1) void'(rxq1.pop_front());
        if (i_fsi_rx_valid) begin
            if (!i_fsi_rx_channel) begin
                if (n0 < DEPTH || rd0) rxq0.push_back(i_fsi_rx_data); else m_ovf[0] = 1'b1;
            end else begin
                if (n1 < DEPTH || rd1) rxq1.push_back(i_fsi_rx_data); else m_ovf[1] = 1'b1;
            end
        end
        // TX
        acc0 = i_tx0_write && (t0 < DEPTH || (pop && popc == 0));
        acc1 = i_tx1_write && (t1 < DEPTH || (pop && popc == 1));
        if (pop) begin
            if (popc) void'(txq1.pop_front()); else void'(txq0.pop_front());
            m_valid = 0;
            m_rr    = popc;
        end else if (start) begin
            m_valid = 1;
            m_chan  = selc;
            m_data  = seld;
        end
        if (acc0) txq0.push_back(i_tx0_data);
        if (acc1) txq1.push_back(i_tx1_data);
        m_ready = nready;
    endtask

    initial forever begin
        @(posedge i_clk);
        model_step();
    end

    initial forever begin
        @(negedge i_clk);
        if (cmp_en) begin
            check("rx0_empty", o_rx0_empty, rxq0.size() == 0);
            check("rx1_empty", o_rx1_empty, rxq1.size() == 0);
            if (rxq0.size() > 0) check("rx0_data", o_rx0_data, rxq0[0]);
            if (rxq1.size() > 0) check("rx1_data", o_rx1_data, rxq1[0]);
            check("tx0_full", o_tx0_full, txq0.size() == DEPTH);
            check("tx1_full", o_tx1_full, txq1.size() == DEPTH);
            check("rx_overflow", o_rx_overflow, m_ovf);
            check("rx_ready", o_fsi_rx_ready, m_ready);
            check("tx_valid", o_fsi_tx_valid, m_valid);
            if (m_valid) begin
                check("tx_channel", o_fsi_tx_channel, m_chan);
                check("tx_data", o_fsi_tx_data, m_data);
            end
        end
    end

    task automatic cyc();
        @(posedge i_clk);
        #1;
    endtask

    task automatic clear_inputs();
        i_fsi_rx_valid = 0; i_rx0_read = 0; i_rx1_read = 0;
        i_tx0_write = 0; i_tx1_write = 0;
    endtask

    task automatic do_reset();
        clear_inputs();
        i_reset = 1;
        cyc(); cyc();
        i_reset = 0;
    endtask

    task automatic rx_pulse(input bit ch, input logic [7:0] d);
        i_fsi_rx_valid = 1; i_fsi_rx_channel = ch; i_fsi_rx_data = d;
        cyc();
        i_fsi_rx_valid = 0;
    endtask

    task automatic rd1_check(input string nm, input logic [7:0] exp);
        check(nm, o_rx1_data, exp);
        i_rx1_read = 1;
        cyc();
        i_rx1_read = 0;
    endtask

    // Engine: drops busy, waits (bounded) for an offer, takes it, then is
    // busy for 20 cycles starting the cycle after acceptance.
    task automatic engine_take(input string nm, input bit exp_ch, input logic [7:0] exp_d);
        bit got = 0;
        i_fsi_tx_busy = 0;
        for (int k = 0; k < 10 && !got; k++) begin
            if (o_fsi_tx_valid) begin
                got = 1;
                check({nm, "_ch"}, o_fsi_tx_channel, exp_ch);
                check({nm, "_data"}, o_fsi_tx_data, exp_d);
                cyc();
                i_fsi_tx_busy = 1;
                repeat (20) cyc();
            end else begin
                cyc();
            end
        end
        if (!got) check({nm, "_timeout"}, 0, 1);
    endtask

    initial begin
        // 1: reset values, then ready after idle
        cyc();
        cmp_en = 1;
        cyc();
        check("rst_ready", o_fsi_rx_ready, 0);
        check("rst_valid", o_fsi_tx_valid, 0);
        check("rst_ch", o_fsi_tx_channel, 0);
        check("rst_data", o_fsi_tx_data, 8'h00);
        check("rst_ovf", o_rx_overflow, 2'b00);
        check("rst_empty", {o_rx0_empty, o_rx1_empty}, 2'b11);
        check("rst_full", {o_tx0_full, o_tx1_full}, 2'b00);
        i_reset = 0;
        cyc(); cyc();
        check("t1_ready", o_fsi_rx_ready, 1);
        check("t1_empty", {o_rx0_empty, o_rx1_empty}, 2'b11);
        check("t1_valid", o_fsi_tx_valid, 0);

        // 2: RX demux
        do_reset();
        rx_pulse(0, 8'hA5);
        check("t2_rx0_nonempty", o_rx0_empty, 0);
        rx_pulse(1, 8'h3C);
        rx_pulse(0, 8'h5A);
        check("t2_rx0_head", o_rx0_data, 8'hA5);
        check("t2_rx1_head", o_rx1_data, 8'h3C);
        check("t2_ovf", o_rx_overflow, 2'b00);
        i_rx0_read = 1; cyc(); i_rx0_read = 0;
        check("t2_rx0_second", o_rx0_data, 8'h5A);

        // 3: RX throttle and overflow at depth 4
        do_reset();
        cyc(); cyc();
        check("t3_ready_start", o_fsi_rx_ready, 1);
        rx_pulse(1, 8'hB1);
        rx_pulse(1, 8'hB2);
        rx_pulse(1, 8'hB3);
        cyc();
        check("t3_ready_low", o_fsi_rx_ready, 0);
        rx_pulse(1, 8'hB4);
        check("t3_no_ovf_yet", o_rx_overflow, 2'b00);
        rx_pulse(1, 8'hB5);
        check("t3_ovf", o_rx_overflow, 2'b10);
        rd1_check("t3_head_b1", 8'hB1);
        rx_pulse(1, 8'hB6);
        check("t3_ovf_sticky", o_rx_overflow, 2'b10);
        rd1_check("t3_head_b2", 8'hB2);
        rd1_check("t3_head_b3", 8'hB3);
        rd1_check("t3_head_b4", 8'hB4);
        rd1_check("t3_head_b6", 8'hB6);
        check("t3_drained", o_rx1_empty, 1);

        // 4: TX arbitration order
        i_fsi_tx_busy = 1;
        do_reset();
        i_tx0_write = 1; i_tx0_data = 8'h11; i_tx1_write = 1; i_tx1_data = 8'h33;
        cyc();
        i_tx0_data = 8'h22; i_tx1_data = 8'h44;
        cyc();
        i_tx0_write = 0; i_tx1_write = 0;
        engine_take("t4_b0", 0, 8'h11);
`ifdef USB_FSI_TX_STRICT_PRIORITY_EN
        engine_take("t4_b1", 0, 8'h22);
        engine_take("t4_b2", 1, 8'h33);
`else
        engine_take("t4_b1", 1, 8'h33);
        engine_take("t4_b2", 0, 8'h22);
`endif
        engine_take("t4_b3", 1, 8'h44);

        // 5: offer held stable while busy
        i_fsi_tx_busy = 1;
        do_reset();
        for (int k = 0; k < 4; k++) begin
            i_tx0_write = 1; i_tx0_data = 8'h71 + 8'(k);
            cyc();
        end
        i_tx0_write = 0;
        check("t5_full", o_tx0_full, 1);
        i_fsi_tx_busy = 0;
        cyc();
        i_fsi_tx_busy = 1;
        for (int k = 0; k < 50; k++) begin
            check("t5_hold_valid", o_fsi_tx_valid, 1);
            check("t5_hold_data", o_fsi_tx_data, 8'h71);
            check("t5_hold_ch", o_fsi_tx_channel, 0);
            check("t5_hold_full", o_tx0_full, 1);
            cyc();
        end
        i_fsi_tx_busy = 0;
        cyc();
        i_fsi_tx_busy = 1;
        check("t5_accepted_valid", o_fsi_tx_valid, 0);
        check("t5_accepted_full", o_tx0_full, 0);

        // 6: reset during OFFER
        do_reset();
        i_tx0_write = 1; i_tx0_data = 8'h61; i_tx1_write = 1; i_tx1_data = 8'h62;
        cyc();
        i_tx0_write = 0; i_tx1_write = 0;
        for (int k = 0; k < 5; k++) rx_pulse(0, 8'hC0 + 8'(k));
        check("t6_ovf_set", o_rx_overflow, 2'b01);
        i_fsi_tx_busy = 0;
        cyc();
        i_fsi_tx_busy = 1;
        check("t6_offer", o_fsi_tx_valid, 1);
        check("t6_offer_data", o_fsi_tx_data, 8'h61);
        i_reset = 1;
        cyc();
        check("t6_valid", o_fsi_tx_valid, 0);
        check("t6_empty", {o_rx0_empty, o_rx1_empty}, 2'b11);
        check("t6_ovf", o_rx_overflow, 2'b00);
        check("t6_full", {o_tx0_full, o_tx1_full}, 2'b00);
        i_reset = 0;
        i_fsi_tx_busy = 0;
        cyc(); cyc(); cyc();
        check("t6_tx_flushed", o_fsi_tx_valid, 0);

        // Randomized phase against the reference model
        for (int c = 0; c < 4000; c++) begin
            i_reset          = ($urandom_range(0, 399) == 0);
            i_fsi_rx_valid   = ($urandom_range(0, 2) == 0);
            i_fsi_rx_channel = 1'($urandom);
            i_fsi_rx_data    = 8'($urandom);
            i_rx0_read       = ($urandom_range(0, 2) == 0);
            i_rx1_read       = ($urandom_range(0, 2) == 0);
            i_tx0_write      = ($urandom_range(0, 2) == 0);
            i_tx0_data       = 8'($urandom);
            i_tx1_write      = ($urandom_range(0, 2) == 0);
            i_tx1_data       = 8'($urandom);
            i_fsi_tx_busy    = ($urandom_range(0, 2) != 0);
            cyc();
        end
        clear_inputs();
        i_reset = 0;
        cyc(); cyc();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
